yapp_router_param: RTL
======================

Name: yapp_router_param

Overview:
Parametrised next-generation YAPP router. It takes length-framed packets on one input port and routes them to NCH output channels, each buffered by a DEPTH-entry first-word-fall-through FIFO. Compared with the current router it adds length-counted framing, enforcement of the host enable register, a separate host read bus, and host-visible drop and parity-error counters. It replaces the current router at the top of the YAPP datapath.

Parameters:
DW, 8, data and header width in bits
ADDR_W, 2, width of header address field (header[ADDR_W-1:0])
NCH, 3, number of output channels; must be 1 to 2**ADDR_W
DEPTH, 16, FIFO entries per channel; must be a power of 2, at least 4
DEF_MAX_PKT, 63, reset value of max-packet-length register
DEF_EN, 1, reset value of router enable register

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high
in_data  in  DW  input byte
in_data_vld  in  1  input byte valid
in_suspend  out  1  backpressure to source
data_out  out  NCH*DW  channel c occupies bits [c*DW +: DW]
data_vld  out  NCH  per-channel head-of-FIFO valid
suspend  in  NCH  per-channel sink backpressure
error  out  1  one-cycle parity-error pulse
hen  in  1  host access strobe
hwr  in  1  1 = write, 0 = read
haddr  in  8  host register address
hwdata  in  8  host write data
hrdata  out  8  host read data

Behaviour:
- Reset: in_suspend=0, data_vld=0, error=0, hrdata=0, FSM=HDR, all FIFOs empty, counters=0, max_pkt=DEF_MAX_PKT, enable=DEF_EN. A reset mid-packet discards the packet and all FIFO contents.
- Input transfer happens when in_data_vld && !in_suspend. Packet = header, then LEN payload bytes, then parity byte. LEN = header[DW-1:ADDR_W]; ADDR = header[ADDR_W-1:0]. The frame ends by count; in_data_vld gaps between bytes are allowed.
- FSM states:
  - HDR: on header transfer:
    - If enable=0, or ADDR>=NCH, or LEN==0, or LEN>max_pkt (width-matched compare): go to DROP; drop_cnt +1.
    - Otherwise: go to LOAD, latch ADDR, load remain=LEN+1, write header to FIFO[ADDR].
  - LOAD: in_suspend = FIFO[ADDR] full (combinational). Each transfer writes FIFO[ADDR] and decrements remain. The transfer at remain==1 is the parity byte; after it, go to HDR.
  - DROP: in_suspend=0. Bytes are consumed without writing, counted by remain. After the parity byte, go to HDR.
- Header accept in HDR is gated by the destination FIFO: in_suspend=1 in HDR when the target FIFO (addressed by in_data) is full and the header is not being dropped.
- Parity = XOR of header and all payload bytes. The parity byte is written to the FIFO unchanged. On mismatch, error=1 in the following cycle only and perr_cnt +1. Parity is not checked in DROP.
- FIFO: data_vld[c] = !empty[c]. data_out holds the head entry. A pop happens when data_vld[c] && !suspend[c]. Simultaneous push and pop is legal when full (the pop frees a slot in the same cycle; in_suspend does not assert). Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit. A push is ignored when full (cannot happen when the handshake is obeyed).
- Host interface, one cycle, posedge:
  - Write: hen&&hwr writes the register. 0x00 sets max_pkt; 0x01 sets enable=hwdata[0]. Writes to 0x02, 0x03 and unmapped addresses are ignored.
  - Read: hen&&!hwr sets hrdata on the next edge. 0x00=max_pkt, 0x01={7'b0,enable}, 0x02=drop_cnt, 0x03=perr_cnt, other addresses=0. Reading 0x02 or 0x03 clears that counter in the same edge.
  - hrdata holds its value between reads.
- Counters: 8-bit, saturate at 255. If an increment coincides with read-clear, the result is 1.
- A change to enable or max_pkt affects only headers accepted after the write edge.

Test Plan:
- Reset, then send header 0x11 (LEN 4, ADDR 1), payload 01 02 03 04, parity 0x15, with suspend=0 -> data_vld[1] rises one cycle after the header push; 6 bytes appear in order; error stays 0.
- Send header with ADDR 3 (NCH=3), LEN 2 -> 4 bytes consumed, no FIFO written; read 0x02 returns 1, then the next read returns 0.
- Write max_pkt=4; send LEN 5 -> dropped. Write enable=0; send a valid packet -> dropped; drop_cnt=2.
- Hold suspend[0]=1; stream a LEN-20 packet to ch0 -> in_suspend asserts after 16 bytes pushed. Release suspend -> the stream resumes with no loss or duplication; the simultaneous push/pop at full succeeds.
- Send a packet with parity corrupted to 0x00 -> error high exactly one cycle after the parity byte; perr_cnt=1; the byte is still delivered.
- Assert reset mid-LOAD -> data_vld=0, FSM=HDR, counters=0. The next valid packet routes correctly.

Source files
------------

// File: rtl/yapp_router_param.sv
// yapp_router_param
//   Length-framed YAPP packet router. One input byte stream is split into
//   packets (header, LEN payload bytes, parity byte). Each packet goes to one of
//   NCH output channels, and each channel has a DEPTH-entry first-word-fall-through
//   FIFO. Packets are dropped when the router is disabled, the address is out
//   of range, LEN is zero, or LEN is above the host max_pkt register. A small
//   host bus gives access to max_pkt, enable and the clear-on-read drop and
//   parity-error counters.
//
// Ports
//   clock, reset             system clock; asynchronous active-high reset
//   in_data/in_data_vld      input byte stream
//   in_suspend               backpressure to the source
//   data_out/data_vld        per-channel FIFO head; channel c at [c*DW +: DW]
//   suspend                  per-channel sink backpressure
//   error                    one-cycle pulse on parity mismatch
//   hen/hwr/haddr/hwdata     host strobe, write select, address, write data
//   hrdata                   host read data, held between reads
module yapp_router_param #(
  parameter int DW          = 8,
  parameter int ADDR_W      = 2,
  parameter int NCH         = 3,
  parameter int DEPTH       = 16,
  parameter int DEF_MAX_PKT = 63,
  parameter int DEF_EN      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DW-1:0]     in_data,
  input  logic              in_data_vld,
  output logic              in_suspend,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    data_vld,
  input  logic [NCH-1:0]    suspend,
  output logic              error,
  input  logic              hen,
  input  logic              hwr,
  input  logic [7:0]        haddr,
  input  logic [7:0]        hwdata,
  output logic [7:0]        hrdata
);

  localparam int LW = DW - ADDR_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LW > 8) ? LW : 8;
  localparam logic [ADDR_W:0] NCH_V = (ADDR_W+1)'(NCH);

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_DROP} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] hdr_addr;
  logic [LW-1:0]     hdr_len;
  logic [ADDR_W-1:0] route;
  logic [LW:0]       remain;
  logic [DW-1:0]     par_acc;
  logic [7:0]        max_pkt;
  logic              enable;
  logic [7:0]        drop_cnt;
  logic [7:0]        perr_cnt;

  logic [NCH-1:0] fifo_full;
  logic [NCH-1:0] fifo_pop;
  logic [NCH-1:0] fifo_push;

  logic hdr_bad;
  logic tgt_blocked;
  logic load_blocked;
  logic xfer;
  logic last_byte;
  logic drop_inc;
  logic par_bad;
  logic rd_drop;
  logic rd_perr;

  // Saturating 8-bit counter step; a read-clear coinciding with an increment
  // leaves the new event counted.
  function automatic logic [7:0] cnt_next(input logic [7:0] cur,
                                          input logic inc, input logic clr);
    if (clr) return inc ? 8'd1 : 8'd0;
    if (inc && (cur != 8'hFF)) return cur + 8'd1;
    return cur;
  endfunction

  assign hdr_addr  = in_data[ADDR_W-1:0];
  assign hdr_len   = in_data[DW-1:ADDR_W];
  assign last_byte = (remain == (LW+1)'(1));

  assign hdr_bad = !enable
                || ({1'b0, hdr_addr} >= NCH_V)
                || (hdr_len == '0)
                || (CW'(hdr_len) > CW'(max_pkt));

  // A full FIFO that pops this cycle still accepts a push, so it only blocks
  // when it is full and its sink is stalled.
  always_comb begin
    tgt_blocked  = 1'b0;
    load_blocked = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (hdr_addr == ADDR_W'(c)) tgt_blocked  = fifo_full[c] && !fifo_pop[c];
      if (route    == ADDR_W'(c)) load_blocked = fifo_full[c] && !fifo_pop[c];
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_HDR;
    else       state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HDR:   if (xfer) state_nxt = hdr_bad ? S_DROP : S_LOAD;
      S_LOAD:  if (xfer && last_byte) state_nxt = S_HDR;
      S_DROP:  if (xfer && last_byte) state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_suspend = 1'b0;
    unique case (state)
      S_HDR:   in_suspend = !hdr_bad && tgt_blocked;
      S_LOAD:  in_suspend = load_blocked;
      default: in_suspend = 1'b0;
    endcase
  end

  assign xfer     = in_data_vld && !in_suspend;
  assign drop_inc = (state == S_HDR) && xfer && hdr_bad;
  assign par_bad  = (state == S_LOAD) && xfer && last_byte && (in_data != par_acc);

  always_comb begin
    fifo_push = '0;
    for (int c = 0; c < NCH; c++) begin
      if ((state == S_HDR) && !hdr_bad && (hdr_addr == ADDR_W'(c))) fifo_push[c] = xfer;
      if ((state == S_LOAD) && (route == ADDR_W'(c)))                fifo_push[c] = xfer;
    end
  end

  // ---- framing control: byte counter, route latch, error pulse ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remain <= '0;
      route  <= '0;
      error  <= 1'b0;
    end else begin
      error <= par_bad;
      if (xfer) begin
        if (state == S_HDR) begin
          remain <= {1'b0, hdr_len} + (LW+1)'(1);
          route  <= hdr_addr;
        end else begin
          remain <= remain - (LW+1)'(1);
        end
      end
    end
  end

  // Running parity: seeded by the header, folded with each payload byte.
  always_ff @(posedge clock) begin
    if (xfer) begin
      if (state == S_HDR)                    par_acc <= in_data;
      else if (state == S_LOAD && !last_byte) par_acc <= par_acc ^ in_data;
    end
  end

  // ---- host registers and counters ----
  assign rd_drop = hen && !hwr && (haddr == 8'h02);
  assign rd_perr = hen && !hwr && (haddr == 8'h03);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_pkt  <= 8'(DEF_MAX_PKT);
      enable   <= (DEF_EN != 0);
      drop_cnt <= '0;
      perr_cnt <= '0;
      hrdata   <= '0;
    end else begin
      drop_cnt <= cnt_next(drop_cnt, drop_inc, rd_drop);
      perr_cnt <= cnt_next(perr_cnt, par_bad, rd_perr);
      if (hen && hwr) begin
        if (haddr == 8'h00) max_pkt <= hwdata;
        if (haddr == 8'h01) enable  <= hwdata[0];
      end
      if (hen && !hwr) begin
        case (haddr)
          8'h00:   hrdata <= max_pkt;
          8'h01:   hrdata <= {7'b0, enable};
          8'h02:   hrdata <= drop_cnt;
          8'h03:   hrdata <= perr_cnt;
          default: hrdata <= 8'h00;
        endcase
      end
    end
  end

  // ---- per-channel FWFT FIFOs ----
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = fifo_push[c] && (!full || fifo_pop[c]);

    assign fifo_full[c]          = full;
    assign fifo_pop[c]           = !empty && !suspend[c];
    assign data_vld[c]           = !empty;
    assign data_out[c*DW +: DW]  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push)     wr_ptr <= wr_ptr + (AW+1)'(1);
        if (fifo_pop[c]) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

endmodule
